// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset CPU: sequences fetch, decode,
// execute, memory and write-back, with sticky traps for illegal ops and bus timeouts.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        alu_zero,
   output logic        pc_we,
   output logic        pc_src,
   output logic        ir_we,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic [1:0]  imm_sel,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        illegal,
   output logic        bus_err,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_NONE   = 3'd0,
      C_R      = 3'd1,
      C_IALU   = 3'd2,
      C_LOAD   = 3'd3,
      C_STORE  = 3'd4,
      C_BRANCH = 3'd5
   } cls_t;

   state_t          r_state, w_next;
   cls_t            r_cls, w_dec_cls;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_ill, r_berr;
   logic            w_set_ill, w_set_berr, w_to_hit, w_taken;
   logic [1:0]      w_imm;
   logic [2:0]      w_funct3;
   logic            w_unused_instr;

   logic            w_pc_we, w_pc_src, w_ir_we, w_mem_req, w_mem_we, w_mem_addr_sel;
   logic [1:0]      w_imm_sel, w_alu_src_b, w_alu_op;
   logic            w_reg_we, w_wb_sel;

   assign w_funct3       = instr[14:12];
   assign w_unused_instr = &{instr[31:15], instr[11:7]};
   assign w_to_hit       = (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));
   assign w_taken        = ((w_funct3 == 3'b000) && alu_zero) ||
                           ((w_funct3 == 3'b001) && !alu_zero);

   always_comb begin
      w_dec_cls = C_NONE;
      case (instr[6:0])
         7'b0110011: w_dec_cls = C_R;
         7'b0010011: w_dec_cls = C_IALU;
         7'b0000011: if (w_funct3 == 3'b010) w_dec_cls = C_LOAD;
         7'b0100011: if (w_funct3 == 3'b010) w_dec_cls = C_STORE;
         7'b1100011: if (w_funct3 == 3'b000 || w_funct3 == 3'b001) w_dec_cls = C_BRANCH;
         default:    w_dec_cls = C_NONE;
      endcase
   end

   always_comb begin
      case (r_cls)
         C_STORE:  w_imm = 2'b01;
         C_BRANCH: w_imm = 2'b10;
         default:  w_imm = 2'b00;
      endcase
   end

   always_comb begin
      w_next         = r_state;
      w_set_ill      = 1'b0;
      w_set_berr     = 1'b0;
      w_pc_we        = 1'b0;
      w_pc_src       = 1'b0;
      w_ir_we        = 1'b0;
      w_mem_req      = 1'b0;
      w_mem_we       = 1'b0;
      w_mem_addr_sel = 1'b0;
      w_imm_sel      = 2'b00;
      w_alu_src_b    = 2'b00;
      w_alu_op       = 2'b00;
      w_reg_we       = 1'b0;
      w_wb_sel       = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (mem_ready) begin
               w_ir_we = 1'b1;
               w_pc_we = 1'b1;
               w_next  = S_DECODE;
            end else if (w_to_hit) begin
               w_next     = S_TRAP;
               w_set_berr = 1'b1;
            end
         end
         S_DECODE: begin
            if (w_dec_cls == C_NONE) begin
               w_next    = S_TRAP;
               w_set_ill = 1'b1;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_imm_sel = w_imm;
            case (r_cls)
               C_R: begin
                  w_alu_op = 2'b10;
                  w_next   = S_WB;
               end
               C_IALU: begin
                  w_alu_src_b = 2'b01;
                  w_alu_op    = 2'b10;
                  w_next      = S_WB;
               end
               C_LOAD, C_STORE: begin
                  w_alu_src_b = 2'b01;
                  w_next      = S_MEM;
               end
               C_BRANCH: begin
                  // Branch decision is combinational on alu_zero in this cycle
                  w_alu_op = 2'b01;
                  w_pc_we  = w_taken;
                  w_pc_src = w_taken;
                  w_next   = S_FETCH;
               end
               default: w_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            w_imm_sel      = w_imm;
            w_mem_req      = 1'b1;
            w_mem_addr_sel = 1'b1;
            w_mem_we       = (r_cls == C_STORE);
            w_alu_src_b    = 2'b01;
            if (mem_ready) begin
               w_next = (r_cls == C_STORE) ? S_FETCH : S_WB;
            end else if (w_to_hit) begin
               w_next     = S_TRAP;
               w_set_berr = 1'b1;
            end
         end
         S_WB: begin
            w_imm_sel = w_imm;
            w_reg_we  = 1'b1;
            w_wb_sel  = (r_cls == C_LOAD);
            w_next    = S_FETCH;
         end
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_FETCH;
         r_cls    <= C_NONE;
         r_to_cnt <= '0;
         r_ill    <= 1'b0;
         r_berr   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) r_cls <= w_dec_cls;
         // Any state change clears the count, covering entry to FETCH and MEM
         if (w_next != r_state)
            r_to_cnt <= '0;
         else if (w_mem_req && !mem_ready)
            r_to_cnt <= r_to_cnt + TO_W'(1);
         if (w_set_ill)  r_ill  <= 1'b1;
         if (w_set_berr) r_berr <= 1'b1;
      end
   end

   // Reset masks every output in the same cycle it is asserted
   assign pc_we        = !rst && w_pc_we;
   assign pc_src       = !rst && w_pc_src;
   assign ir_we        = !rst && w_ir_we;
   assign mem_req      = !rst && w_mem_req;
   assign mem_we       = !rst && w_mem_we;
   assign mem_addr_sel = !rst && w_mem_addr_sel;
   assign imm_sel      = rst ? 2'b00 : w_imm_sel;
   assign alu_src_b    = rst ? 2'b00 : w_alu_src_b;
   assign alu_op       = rst ? 2'b00 : w_alu_op;
   assign reg_we       = !rst && w_reg_we;
   assign wb_sel       = !rst && w_wb_sel;
   assign illegal      = !rst && r_ill;
   assign bus_err      = !rst && r_berr;
   assign state_dbg    = rst ? 3'd0 : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle
// and compares the full output vector against hand-computed values.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        mem_ready;
   logic        alu_zero;
   logic        pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_sel;
   logic [1:0]  imm_sel, alu_src_b, alu_op;
   logic        reg_we, wb_sel, illegal, bus_err;
   logic [2:0]  state_dbg;
   logic [18:0] obs;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   localparam logic [31:0] ADD  = 32'h002081B3;
   localparam logic [31:0] LW   = 32'h0000A183;
   localparam logic [31:0] SW   = 32'h0020A023;
   localparam logic [31:0] BEQ  = 32'h00208463;
   localparam logic [31:0] BNE  = 32'h00209463;
   localparam logic [31:0] ADDI = 32'h00108093;
   localparam logic [31:0] BAD  = 32'h0000007F;
   localparam logic [31:0] LB   = 32'h00008183;

   // strobe field order: pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_sel
   localparam logic [5:0] FET_RDY = 6'b101100;
   localparam logic [5:0] FET_WT  = 6'b000100;
   localparam logic [5:0] MEM_LD  = 6'b000101;
   localparam logic [5:0] MEM_ST  = 6'b000111;
   localparam logic [5:0] BR_TK   = 6'b110000;

   multicycle_ctrl #(.MEM_TIMEOUT(8), .TO_W(4)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .imm_sel(imm_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   assign obs = {state_dbg, pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_sel,
                 imm_sel, alu_src_b, alu_op, reg_we, wb_sel, illegal, bus_err};

   function automatic logic [18:0] ev(input logic [2:0] st, input logic [5:0] strb,
                                      input logic [1:0] imm, input logic [1:0] asrc,
                                      input logic [1:0] aop, input logic rwe, input logic wsel,
                                      input logic ill, input logic berr);
      return {st, strb, imm, asrc, aop, rwe, wsel, ill, berr};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at posedge+1 with inputs already set; checks mid-cycle, then advances
   task automatic step(input string tag, input logic [18:0] exp);
      #1;
      check(tag, {13'd0, obs}, {13'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step("rst_hold0", 19'd0);
      step("rst_hold1", 19'd0);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      instr     = '0;
      mem_ready = 1'b0;
      alu_zero  = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // R-type: FETCH, DECODE, EXEC, WB
      instr = ADD; mem_ready = 1'b1;
      step("add_fetch",  ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("add_decode", ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("add_exec",   ev(3'd2, 6'd0,    2'b00, 2'b00, 2'b10, 0, 0, 0, 0));
      step("add_wb",     ev(3'd4, 6'd0,    2'b00, 2'b00, 2'b00, 1, 0, 0, 0));

      // Load with three wait cycles in MEM
      instr = LW;
      step("lw_fetch",  ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("lw_decode", ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("lw_exec",   ev(3'd2, 6'd0,    2'b00, 2'b01, 2'b00, 0, 0, 0, 0));
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         step("lw_mem_wait", ev(3'd3, MEM_LD, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0));
      mem_ready = 1'b1;
      step("lw_mem_done", ev(3'd3, MEM_LD, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0));
      step("lw_wb",       ev(3'd4, 6'd0,   2'b00, 2'b00, 2'b00, 1, 1, 0, 0));

      // Store returns straight to FETCH after MEM
      instr = SW;
      step("sw_fetch",  ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("sw_decode", ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("sw_exec",   ev(3'd2, 6'd0,    2'b01, 2'b01, 2'b00, 0, 0, 0, 0));
      step("sw_mem",    ev(3'd3, MEM_ST,  2'b01, 2'b01, 2'b00, 0, 0, 0, 0));

      // BEQ taken, next instruction's FETCH follows the store directly
      instr = BEQ; alu_zero = 1'b1;
      step("sw_next_fetch", ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("beq_decode",    ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("beq_exec_tk",   ev(3'd2, BR_TK,   2'b10, 2'b00, 2'b01, 0, 0, 0, 0));
      // BEQ not taken
      alu_zero = 1'b0;
      step("beq2_fetch",    ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("beq2_decode",   ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("beq_exec_nt",   ev(3'd2, 6'd0,    2'b10, 2'b00, 2'b01, 0, 0, 0, 0));
      // BNE taken on alu_zero=0
      instr = BNE;
      step("bne_fetch",     ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("bne_decode",    ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("bne_exec_tk",   ev(3'd2, BR_TK,   2'b10, 2'b00, 2'b01, 0, 0, 0, 0));

      // I-ALU
      instr = ADDI;
      step("addi_fetch",  ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("addi_decode", ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("addi_exec",   ev(3'd2, 6'd0,    2'b00, 2'b01, 2'b10, 0, 0, 0, 0));
      step("addi_wb",     ev(3'd4, 6'd0,    2'b00, 2'b00, 2'b00, 1, 0, 0, 0));

      // Illegal opcode: trap is sticky and silent until reset
      instr = BAD;
      step("bad_fetch",  ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("bad_decode", ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      for (int i = 0; i < 20; i++)
         step("bad_trap", ev(3'd7, 6'd0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
      do_reset();

      // Load with unsupported funct3 also traps
      instr = LB;
      step("lb_fetch",  ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("lb_decode", ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("lb_trap",   ev(3'd7, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
      do_reset();

      // FETCH timeout after 8 cycles without mem_ready
      instr = ADD; mem_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         step("fetch_wait", ev(3'd0, FET_WT, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("fetch_to_trap0", ev(3'd7, 6'd0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1));
      step("fetch_to_trap1", ev(3'd7, 6'd0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1));
      do_reset();

      // mem_ready on the timeout cycle wins
      for (int i = 0; i < 7; i++)
         step("edge_wait", ev(3'd0, FET_WT, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      mem_ready = 1'b1;
      step("edge_ready",  ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("edge_decode", ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("edge_exec",   ev(3'd2, 6'd0,    2'b00, 2'b00, 2'b10, 0, 0, 0, 0));
      step("edge_wb",     ev(3'd4, 6'd0,    2'b00, 2'b00, 2'b00, 1, 0, 0, 0));

      // MEM timeout: counter restarts on MEM entry
      instr = LW;
      step("lwto_fetch",  ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("lwto_decode", ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("lwto_exec",   ev(3'd2, 6'd0,    2'b00, 2'b01, 2'b00, 0, 0, 0, 0));
      mem_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         step("lwto_mem", ev(3'd3, MEM_LD, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0));
      step("lwto_trap", ev(3'd7, 6'd0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1));
      do_reset();

      // Reset asserted mid-MEM drops mem_req in the same cycle
      mem_ready = 1'b1;
      step("rm_fetch",  ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("rm_decode", ev(3'd1, 6'd0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step("rm_exec",   ev(3'd2, 6'd0,    2'b00, 2'b01, 2'b00, 0, 0, 0, 0));
      mem_ready = 1'b0;
      step("rm_mem",    ev(3'd3, MEM_LD,  2'b00, 2'b01, 2'b00, 0, 0, 0, 0));
      rst = 1'b1;
      step("rm_rst_cycle", 19'd0);
      rst = 1'b0;
      mem_ready = 1'b1;
      step("rm_after_fetch", ev(3'd0, FET_RDY, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
